// File: rtl/data_sram_arbiter_pkg.sv
// Shared definitions for the data SRAM arbiter.
//   owner_e : which master owns the read whose data returns next cycle
//   CNT_W   : width of the aux starvation counter (limits up to 15)
package data_sram_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_PIPE = 2'd1,
        OWN_AUX  = 2'd2
    } owner_e;

    localparam int CNT_W = 4;

endpackage

// File: rtl/data_sram_arbiter.sv
// Data SRAM arbiter: shares the single-port data SRAM between the pipeline
// load/store path (issue in EXE, data in MEM) and one auxiliary master
// (debug/DMA). The pipeline has fixed priority; after STARVE_LIMIT
// consecutive denied aux cycles the aux master is granted once.
// The owner of each read is remembered for one cycle so the SRAM read data
// (1-cycle latency) is flagged valid to the right requester.
//
// Ports
//   clk, resetn                       clock, asynchronous active-low reset
//   pipe_req/wr/wstrb/addr/wdata      pipeline request (held until pipe_gnt)
//   pipe_flush                        kills pipe grant and pipe response
//   pipe_gnt, pipe_rvalid, pipe_rdata pipeline grant / load response
//   aux_req/wr/wstrb/addr/wdata       auxiliary request (held until aux_gnt)
//   aux_gnt, aux_rvalid, aux_rdata    auxiliary grant / read response
//   data_sram_en/wen/addr/wdata       SRAM command pins
//   data_sram_rdata                   SRAM read data, 1 cycle after a read
module data_sram_arbiter
    import data_sram_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                resetn,

    input  logic                pipe_req,
    input  logic                pipe_wr,
    input  logic [DATA_W/8-1:0] pipe_wstrb,
    input  logic [ADDR_W-1:0]   pipe_addr,
    input  logic [DATA_W-1:0]   pipe_wdata,
    input  logic                pipe_flush,
    output logic                pipe_gnt,
    output logic                pipe_rvalid,
    output logic [DATA_W-1:0]   pipe_rdata,

    input  logic                aux_req,
    input  logic                aux_wr,
    input  logic [DATA_W/8-1:0] aux_wstrb,
    input  logic [ADDR_W-1:0]   aux_addr,
    input  logic [DATA_W-1:0]   aux_wdata,
    output logic                aux_gnt,
    output logic                aux_rvalid,
    output logic [DATA_W-1:0]   aux_rdata,

    output logic                data_sram_en,
    output logic [DATA_W/8-1:0] data_sram_wen,
    output logic [ADDR_W-1:0]   data_sram_addr,
    output logic [DATA_W-1:0]   data_sram_wdata,
    input  logic [DATA_W-1:0]   data_sram_rdata
);

    localparam int              STRB_W = DATA_W / 8;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= LIMIT) ? LIMIT : v + CNT_W'(1);
    endfunction

    logic [CNT_W-1:0] starve_cnt_p1;
    logic [CNT_W-1:0] starve_cnt_nxt;
    owner_e           rd_owner_p1;
    owner_e           rd_owner_nxt;
    logic             force_aux;
    logic             win_wr;
    logic [STRB_W-1:0] win_wstrb;

    // ---- Stage 0: arbitration and SRAM command (combinational) ----
    always_comb begin
        force_aux       = (starve_cnt_p1 == LIMIT);
        // resetn gating keeps the SRAM idle while reset is held
        pipe_gnt        = resetn & pipe_req & ~pipe_flush & ~(force_aux & aux_req);
        aux_gnt         = resetn & aux_req & ~pipe_gnt;
        data_sram_en    = pipe_gnt | aux_gnt;

        data_sram_addr  = pipe_gnt ? pipe_addr  : aux_addr;
        data_sram_wdata = pipe_gnt ? pipe_wdata : aux_wdata;
        win_wr          = pipe_gnt ? pipe_wr    : aux_wr;
        win_wstrb       = pipe_gnt ? pipe_wstrb : aux_wstrb;
        data_sram_wen   = (data_sram_en && win_wr) ? win_wstrb : '0;

        // A forced grant clears the counter, so priority returns next cycle
        starve_cnt_nxt  = (aux_req && !aux_gnt) ? sat_inc(starve_cnt_p1) : '0;

        rd_owner_nxt    = OWN_NONE;
        if (pipe_gnt && !pipe_wr) begin
            rd_owner_nxt = OWN_PIPE;
        end else if (aux_gnt && !aux_wr) begin
            rd_owner_nxt = OWN_AUX;
        end
    end

    // ---- Stage 0 -> 1 boundary: control state ----
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_cnt_p1 <= '0;
            rd_owner_p1   <= OWN_NONE;
        end else begin
            starve_cnt_p1 <= starve_cnt_nxt;
            rd_owner_p1   <= rd_owner_nxt;
        end
    end

    // ---- Stage 1: read response steering ----
    // A flush in the response cycle drops the pipeline load; aux is never flushed.
    always_comb begin
        pipe_rvalid = (rd_owner_p1 == OWN_PIPE) & ~pipe_flush;
        aux_rvalid  = (rd_owner_p1 == OWN_AUX);
        pipe_rdata  = data_sram_rdata;
        aux_rdata   = data_sram_rdata;
    end

    // A requester that is waiting must keep its command stable until granted.
    // A flushed pipeline request may be replaced.
    a_pipe_stable: assert property (@(posedge clk) disable iff (!resetn)
        (pipe_req && !pipe_gnt && !pipe_flush) |=>
            (!pipe_req || pipe_flush ||
             $stable({pipe_wr, pipe_wstrb, pipe_addr, pipe_wdata})));

    a_aux_stable: assert property (@(posedge clk) disable iff (!resetn)
        (aux_req && !aux_gnt) |=>
            (!aux_req || $stable({aux_wr, aux_wstrb, aux_addr, aux_wdata})));

endmodule
